// File: rtl/aes_pkg.sv
// aes_pkg: AES widths, block type and the round-robin pick helper shared by the arbiter
package aes_pkg;
   localparam int AES_BLK_W = 128;
   localparam int AES_KEY_W = 128;
   localparam int RR_MAX = 8;
   localparam int RR_IW = 3;
   typedef logic [AES_BLK_W-1:0] aes_blk_t;
   // Returns {found, index}; vec bits at or above the requester count must be zero
   function automatic logic [RR_IW:0] rr_pick(input logic [RR_MAX-1:0] vec, input logic [RR_IW-1:0] ptr);
      logic [RR_IW:0] r;
      logic [RR_IW-1:0] j;
      r = '0;
      for (int i = RR_MAX - 1; i >= 0; i--) begin
         j = ptr + RR_IW'(i);
         if (vec[j]) r = {1'b1, j};
      end
      return r;
   endfunction
endpackage

// File: rtl/aes_pipe_arbiter_if.sv
// aes_pipe_arbiter_if: requester and response handshake bundle of the AES arbiter
interface aes_pipe_arbiter_if #(parameter int NREQ = 4);
   import aes_pkg::*;
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*AES_BLK_W-1:0] req_data;
   logic [NREQ*AES_KEY_W-1:0] req_key;
   logic rsp_valid;
   logic rsp_ready;
   aes_blk_t rsp_data;
   logic [IW-1:0] rsp_id;
   logic busy;
   modport master(output req_valid, req_data, req_key, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_id, busy);
   modport slave(input req_valid, req_data, req_key, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_id, busy);
endinterface

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: first-word-fall-through result FIFO with occupancy count
module aes_out_fifo #(
   parameter int WIDTH = 130,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign empty = count == '0;
   assign pop_data = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_data;
   // The credit scheme upstream makes a push into a full FIFO unreachable
   assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/aes_pipe_arbiter.sv
// aes_pipe_arbiter: round-robin sharing of one pipelined AES-128 core behind a credit-guarded result FIFO
module aes_pipe_arbiter
   import aes_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PIPE_LAT = 10,
   parameter int OUT_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_pipe_arbiter_if.slave    bus,
   output aes_blk_t             cph_datain,
   output logic [AES_KEY_W-1:0] cph_key,
   input  aes_blk_t             cph_dataout
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(OUT_DEPTH) + 1;
   logic [IW-1:0] ptr, gnt_id;
   logic [RR_IW:0] pick;
   logic grant, credit, fifo_empty;
   logic [CW-1:0] fifo_count, inflight;
   logic [PIPE_LAT:0] tag_vld;
   logic [IW-1:0] tag_id [PIPE_LAT+1];
   logic [AES_BLK_W+IW-1:0] fifo_out;
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= PIPE_LAT; i++) inflight = inflight + CW'(tag_vld[i]);
   end
   // Every block in the core already owns a FIFO slot, so the core never has to stall
   assign credit = 32'(fifo_count) + 32'(inflight) < OUT_DEPTH;
   assign pick = rr_pick(RR_MAX'(bus.req_valid), RR_IW'(ptr));
   assign gnt_id = IW'(pick[RR_IW-1:0]);
   assign grant = pick[RR_IW] & credit;
   assign bus.req_ready = grant ? NREQ'(1) << gnt_id : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr <= '0;
         cph_datain <= '0;
         cph_key <= '0;
         tag_vld <= '0;
         for (int i = 0; i <= PIPE_LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_vld <= {tag_vld[PIPE_LAT-1:0], grant};
         tag_id[0] <= gnt_id;
         for (int i = 1; i <= PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
         if (grant) begin
            ptr <= gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
            cph_datain <= bus.req_data[AES_BLK_W*gnt_id +: AES_BLK_W];
            cph_key <= bus.req_key[AES_KEY_W*gnt_id +: AES_KEY_W];
         end
      end
   aes_out_fifo #(.WIDTH(AES_BLK_W + IW), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(tag_vld[PIPE_LAT]),
      .push_data({tag_id[PIPE_LAT], cph_dataout}),
      .pop(bus.rsp_valid & bus.rsp_ready),
      .pop_data(fifo_out),
      .empty(fifo_empty),
      .count(fifo_count)
   );
   assign bus.rsp_valid = !fifo_empty;
   assign bus.rsp_data = fifo_empty ? '0 : fifo_out[AES_BLK_W-1:0];
   assign bus.rsp_id = fifo_empty ? '0 : fifo_out[AES_BLK_W +: IW];
   assign bus.busy = |tag_vld | !fifo_empty;
endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// tb_aes_pipe_arbiter: arbiter plus behavioural pipelined AES core, checked every cycle against a queue model
module tb_aes_pipe_arbiter;
   import aes_pkg::*;
   localparam int NREQ = 4;
   localparam int PIPE_LAT = 10;
   localparam int OUT_DEPTH = 16;
   localparam int LAT = PIPE_LAT + 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   aes_blk_t cph_datain, cph_key, cph_dataout;
   aes_pipe_arbiter_if #(.NREQ(NREQ)) bus();
   aes_pipe_arbiter #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .cph_datain(cph_datain),
      .cph_key(cph_key),
      .cph_dataout(cph_dataout)
   );
   always #5 clk = ~clk;
   int n_tests = 0;
   int n_fail = 0;
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] y, input int n);
      return (y << n) | (y >> (8 - n));
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] k [16];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         k[i] = key[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         k[0] = k[0] ^ sb[k[13]] ^ rc;
         k[1] = k[1] ^ sb[k[14]];
         k[2] = k[2] ^ sb[k[15]];
         k[3] = k[3] ^ sb[k[12]];
         for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
         rc = xt(rc);
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = sb[s[w+4*((c+w)%4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            s[4*c]   = r < 10 ? xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3 : a0;
            s[4*c+1] = r < 10 ? a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3 : a1;
            s[4*c+2] = r < 10 ? a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3 : a2;
            s[4*c+3] = r < 10 ? xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3) : a3;
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   initial begin
      logic [7:0] y;
      for (int x = 0; x < 256; x++) begin
         y = 8'(x);
         for (int e = 0; e < 253; e++) y = gmul(y, 8'(x));
         sb[x] = y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
      end
   end

   // Behavioural core: result of the block sampled at an edge appears PIPE_LAT cycles later
   aes_blk_t core_pipe [PIPE_LAT];
   always @(posedge clk) begin
      core_pipe[0] <= aes_enc(cph_datain, cph_key);
      for (int i = 1; i < PIPE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign cph_dataout = core_pipe[PIPE_LAT-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Model: outstanding blocks in issue order; a block is visible LAT cycles after its accept
   typedef struct {
      int t;
      int id;
      logic [127:0] ct;
   } ent_t;
   ent_t q[$];
   int cyc = 0;
   int mptr = 0;
   int g;
   int n_acc = 0;
   int n_pop = 0;
   logic ev;
   logic [127:0] m_din = '0;
   logic [127:0] m_key = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", 128'(bus.req_ready), 0);
         chk("rst_rsp_valid", 128'(bus.rsp_valid), 0);
         chk("rst_rsp_data", bus.rsp_data, 0);
         chk("rst_rsp_id", 128'(bus.rsp_id), 0);
         chk("rst_busy", 128'(bus.busy), 0);
         chk("rst_cph_datain", cph_datain, 0);
         q.delete();
         mptr = 0;
         m_din = '0;
         m_key = '0;
      end else begin
         g = -1;
         if (q.size() < OUT_DEPTH)
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && bus.req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
         ev = 1'b0;
         if (q.size() > 0) ev = q[0].t + LAT <= cyc;
         chk("req_ready", 128'(bus.req_ready), g >= 0 ? 128'(1) << g : 128'(0));
         chk("rsp_valid", 128'(bus.rsp_valid), 128'(ev));
         chk("busy", 128'(bus.busy), 128'(q.size() > 0));
         chk("cph_datain", cph_datain, m_din);
         chk("cph_key", cph_key, m_key);
         if (ev) begin
            chk("rsp_data", bus.rsp_data, q[0].ct);
            chk("rsp_id", 128'(bus.rsp_id), 128'(q[0].id));
            if (bus.rsp_ready) begin
               void'(q.pop_front());
               n_pop++;
            end
         end
         if (g >= 0) begin
            m_din = bus.req_data[128*g +: 128];
            m_key = bus.req_key[128*g +: 128];
            q.push_back('{cyc, g, aes_enc(m_din, m_key)});
            mptr = (g + 1) % NREQ;
            n_acc++;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, acc, pops, a0, p0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      bus.req_data = '0;
      bus.req_key = '0;
      repeat (2) tick();
      @(negedge clk);
      chk("t0_busy", 128'(bus.busy), 0);
      chk("t0_rsp_valid", 128'(bus.rsp_valid), 0);
      tick();
      rst_n = 1'b1;
      // FIPS-197 C.1 vector through requester 0
      bus.req_data[127:0] = 128'h00112233445566778899aabbccddeeff;
      bus.req_key[127:0] = 128'h000102030405060708090a0b0c0d0e0f;
      bus.req_valid = 4'b0001;
      @(negedge clk);
      chk("t1_accept", 128'(bus.req_ready), 1);
      tick();
      bus.req_valid = '0;
      k = 1;
      while (k < 40) begin
         @(negedge clk);
         if (bus.rsp_valid) break;
         tick();
         k++;
      end
      chk("t1_latency", 128'(k), 12);
      chk("t1_ct", bus.rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("t1_id", 128'(bus.rsp_id), 0);
      tick();
      // all requesters streaming
      do_reset();
      bus.req_valid = 4'hf;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i < 8) chk("t2_grant", 128'(bus.req_ready), 128'(1) << (i % 4));
         if (i >= LAT) chk("t2_nobubble", 128'(bus.rsp_valid), 1);
         if (i >= LAT && i < LAT + 8) chk("t2_rsp_id", 128'(bus.rsp_id), 128'((i - LAT) % 4));
         tick();
      end
      // credit exhaustion with a stalled consumer
      do_reset();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.req_ready[0]) acc++;
         tick();
      end
      chk("t3_accepts", 128'(acc), 16);
      bus.rsp_ready = 1'b1;
      pops = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) chk("t3_no_bypass", 128'(bus.req_ready), 0);
         if (i == 1) chk("t3_resume", 128'(bus.req_ready), 1);
         if (bus.rsp_valid) pops++;
         tick();
      end
      chk("t3_drain", 128'(pops), 16);
      bus.req_valid = '0;
      repeat (30) tick();
      // pointer wrap
      do_reset();
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("t4_g2", 128'(bus.req_ready), 4'b0100);
      tick();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("t4_wrap", 128'(bus.req_ready), 4'b0010);
      tick();
      bus.req_valid = 4'b0011;
      @(negedge clk);
      chk("t4_from2", 128'(bus.req_ready), 4'b0001);
      tick();
      bus.req_valid = 4'b1010;
      @(negedge clk);
      chk("t4_from1", 128'(bus.req_ready), 4'b0010);
      tick();
      bus.req_valid = '0;
      repeat (20) tick();
      // reset with blocks in flight
      do_reset();
      bus.req_valid = 4'hf;
      repeat (6) tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("t5_busy_pre", 128'(bus.busy), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_busy", 128'(bus.busy), 0);
      chk("t5_rsp_valid", 128'(bus.rsp_valid), 0);
      repeat (5) tick();
      rst_n = 1'b1;
      pops = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) pops++;
         tick();
      end
      chk("t5_stale", 128'(pops), 0);
      // random traffic with alternating consumer pressure
      a0 = n_acc;
      p0 = n_pop;
      for (int i = 0; i < 10000; i++) begin
         bus.req_valid = NREQ'($urandom_range(0, 15));
         bus.rsp_ready = $urandom_range(0, 99) < (((i / 300) % 2) != 0 ? 15 : 85);
         for (int r = 0; r < NREQ * 4; r++) begin
            bus.req_data[32*r +: 32] = $urandom;
            bus.req_key[32*r +: 32] = $urandom;
         end
         tick();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (60) tick();
      @(negedge clk);
      chk("t6_drained", 128'(n_pop - p0), 128'(n_acc - a0));
      chk("t6_activity", 128'(n_acc - a0 > 1000), 1);
      chk("t6_idle_busy", 128'(bus.busy), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
